// File: rtl/sva_result_collector_pkg.sv
// Shared types and defaults for the SVA verdict collector.
package sva_result_pkg;

  localparam int unsigned TS_WIDTH_DEF   = 16;
  localparam int unsigned CNT_WIDTH_DEF  = 16;
  localparam int unsigned FIFO_DEPTH_DEF = 8;
  localparam int unsigned NUM_VERDICTS   = 3;

  localparam int unsigned SUCC_B = 0;
  localparam int unsigned FAIL_B = 1;
  localparam int unsigned LAZY_B = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PASSING = 2'd1,
    FAILED  = 2'd2
  } status_t;

  typedef struct packed {
    logic [NUM_VERDICTS-1:0] mask;
    logic [TS_WIDTH_DEF-1:0] ts;
  } evt_t;

endpackage

// File: rtl/sva_result_collector_if.sv
// Valid/ready readout port for buffered verdict events.
interface sva_result_collector_if #(
  parameter int unsigned TS_WIDTH = 16
) ();
  logic                evt_valid;
  logic                evt_ready;
  logic [2:0]          evt_mask;
  logic [TS_WIDTH-1:0] evt_ts;

  modport master (output evt_valid, output evt_mask, output evt_ts, input evt_ready);
  modport slave  (input evt_valid, input evt_mask, input evt_ts, output evt_ready);
endinterface

// File: rtl/sva_result_collector_evt_fifo.sv
// Show-ahead FIFO with MSB-wrap pointers; reports a push lost to a full queue.
module sva_evt_fifo #(
  parameter int unsigned DW    = 19,
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_req_i,
  input  logic          pop_req_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_c_o,
  output logic [DW-1:0] head_c_o,
  output logic          drop_c_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_q, rd_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic          empty, full, push, pop;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop      = ~empty & pop_req_i;
  // A full queue still accepts when the head leaves in the same cycle.
  assign push     = push_req_i & (~full | pop);
  assign drop_c_o = push_req_i & full & ~pop;

  assign valid_c_o = ~empty;
  assign head_c_o  = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clr_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/sva_result_collector.sv
// Collects SVA checker verdict edges: timestamps, counts, status and an event queue.
module sva_result_collector
  import sva_result_pkg::*;
#(
  parameter int unsigned TS_WIDTH   = TS_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  period_tick,
  input  logic                  succ_i,
  input  logic                  fail_i,
  input  logic                  lazy_succ_i,
  input  logic                  clr,
  sva_result_collector_if.master evt,
  output logic [CNT_WIDTH-1:0]  succ_cnt,
  output logic [CNT_WIDTH-1:0]  fail_cnt,
  output logic [CNT_WIDTH-1:0]  lazy_cnt,
  output logic [1:0]            status,
  output logic                  first_fail_valid,
  output logic [TS_WIDTH-1:0]   first_fail_ts,
  output logic                  overflow
);
  localparam int unsigned DW = NUM_VERDICTS + TS_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [NUM_VERDICTS-1:0] flags, prev_q, rise;
  logic [TS_WIDTH-1:0]     ts_q;
  logic [CNT_WIDTH-1:0]    cnt_q [NUM_VERDICTS];
  status_t                 state_q, state_d;
  logic                    ffv_q, ovf_q;
  logic [TS_WIDTH-1:0]     fft_q;
  logic                    push_req, drop;
  logic [DW-1:0]           head;

  assign flags    = {lazy_succ_i, fail_i, succ_i};
  assign rise     = flags & ~prev_q;
  assign push_req = (|rise) & ~clr;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prev_q <= '0;
      ts_q   <= '0;
    end else begin
      prev_q <= flags;
      if (period_tick) ts_q <= ts_q + TS_WIDTH'(1);
    end
  end

  // Saturating per-verdict counters.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < NUM_VERDICTS; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_VERDICTS; k++) begin
        if (clr)                               cnt_q[k] <= '0;
        else if (rise[k] && cnt_q[k] != CNT_MAX) cnt_q[k] <= cnt_q[k] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr)                                                       state_d = IDLE;
    else if (rise[FAIL_B])                                         state_d = FAILED;
    else if (state_q == IDLE && (rise[SUCC_B] || rise[LAZY_B]))    state_d = PASSING;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ffv_q <= 1'b0;
      fft_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      ffv_q <= 1'b0;
      fft_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (rise[FAIL_B] && !ffv_q) begin
        ffv_q <= 1'b1;
        fft_q <= ts_q;
      end
      if (drop) ovf_q <= 1'b1;
    end
  end

  sva_evt_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .clr_i      (clr),
    .push_req_i (push_req),
    .pop_req_i  (evt.evt_ready),
    .data_i     ({rise, ts_q}),
    .valid_c_o  (evt.evt_valid),
    .head_c_o   (head),
    .drop_c_o   (drop)
  );

  assign evt.evt_mask      = head[DW-1 -: NUM_VERDICTS];
  assign evt.evt_ts        = head[TS_WIDTH-1:0];
  assign succ_cnt          = cnt_q[SUCC_B];
  assign fail_cnt          = cnt_q[FAIL_B];
  assign lazy_cnt          = cnt_q[LAZY_B];
  assign status            = state_q;
  assign first_fail_valid  = ffv_q;
  assign first_fail_ts     = fft_q;
  assign overflow          = ovf_q;
endmodule

// File: doc/sva_result_collector.md
Name: sva_result_collector

Overview:
- Downstream consumer of the SVA checker FSM's per-evaluation verdict flags (succ, fail, lazy_succ).
- Detects the rising edge of each flag and stamps it with the current user-clock period index.
- Keeps saturating per-verdict counters and a sticky overall pass/fail status.
- Buffers verdict events in a small show-ahead FIFO with a valid/ready readout port for the bench/report logic. Runs entirely in the sys_clk domain.

Parameters:
- TS_WIDTH, 16: width of the period timestamp counter; wraps modulo 2^TS_WIDTH.
- CNT_WIDTH, 16: width of each verdict counter; saturates at all-ones.
- FIFO_DEPTH, 8: event FIFO depth, power of two, >=2.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- period_tick  in  1  one-sys_clk pulse per gclk rising edge (the checker's gclk_posedge_flag)
- succ_i  in  1  checker succ level
- fail_i  in  1  checker fail level
- lazy_succ_i  in  1  checker lazy_succ level
- clr  in  1  synchronous clear of statistics, FIFO and status
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head
- evt_mask  out  3  head verdict mask {lazy,fail,succ}
- evt_ts  out  TS_WIDTH  head period timestamp
- succ_cnt / fail_cnt / lazy_cnt  out  CNT_WIDTH each  saturating counts
- status  out  2  IDLE=0, PASSING=1, FAILED=2
- first_fail_valid  out  1  a fail has been captured
- first_fail_ts  out  TS_WIDTH  timestamp of first fail
- overflow  out  1  sticky: event dropped because FIFO full

Behaviour:
- Reset: all outputs 0, status IDLE, FIFO empty, timestamp 0, flag history 0.
- Edge detect: registered copy of each flag. rise[k] = flag[k] & ~prev[k]. prev updates every cycle, including during clr.
- Timestamp: ts increments by 1 on period_tick and wraps. Unaffected by clr. Events are stamped with the ts value before any same-cycle increment.
- Event: any rise bit set in a cycle -> one FIFO entry {mask = rise, ts}. Simultaneous rises share one entry.
- Counters: each counter increments by 1 on its own rise bit and holds at 2^CNT_WIDTH-1.
- Status FSM:
  - IDLE -> PASSING on rise succ or lazy with no fail.
  - Any state -> FAILED on rise fail. FAILED takes priority over a same-cycle succ.
  - FAILED is sticky until clr.
  - clr -> IDLE.
- First fail: on the first rise fail while first_fail_valid=0, capture ts and set valid. Later fails do not overwrite.
- FIFO: show-ahead. evt_valid = not empty; evt_mask/evt_ts present the head combinationally from storage. Pop when evt_valid & evt_ready.
  - Push when event and (not full, or full with a same-cycle pop).
  - Full with no pop: entry dropped, overflow set. Counters and status still update.
  - Push and pop on empty: entry not visible until the next cycle (valid=0 this cycle).
  - Pointers are (log2 DEPTH + 1) bits, wrap-around with MSB full/empty distinction.
- clr (synchronous, single cycle): zeroes counters, FIFO pointers, overflow, first_fail_valid/ts; status -> IDLE. A same-cycle event is discarded entirely (no count, no push). clr wins over pop.
- Reset mid-operation: asynchronous clear to reset values regardless of FIFO or FSM contents.
- Latency: flag rise at cycle N -> counters/status/evt_valid updated at N+1.

Decomposition:
- Package sva_result_pkg:
  - status_t enum {IDLE, PASSING, FAILED}
  - evt_t packed struct {mask[2:0], ts[TS_WIDTH-1:0]}
  - mask bit index constants SUCC_B=0, FAIL_B=1, LAZY_B=2
- Sub-module sva_evt_fifo: parameterised synchronous show-ahead FIFO with full/empty, push/pop and drop indication.
- Top holds edge detect, timestamp, counters, FSM and first-fail capture.

Test Plan:
- Reset, 3 period_ticks, succ_i pulse high for 2 cycles -> succ_cnt=1, one entry mask=3'b001 ts=3, status PASSING.
- succ_i and fail_i rise in the same cycle at ts=5 -> one entry mask=3'b011 ts=5, both counters +1, status FAILED; later fail at ts=9 -> first_fail_ts stays 5.
- evt_ready=0 and 9 distinct lazy rises with DEPTH=8 -> 8 entries, overflow=1, lazy_cnt=9. Then drain with ready=1 -> entries appear in order with ascending ts, evt_valid falls after the 8th pop.
- FIFO full, new event with evt_ready=1 in the same cycle -> no drop, overflow stays 0, occupancy stays 8.
- CNT_WIDTH=2 with 5 succ rises -> succ_cnt saturates at 3. clr asserted together with a fail rise -> counters 0, FIFO empty, status IDLE, first_fail_valid=0; ts unchanged.
- sys_rst_n asserted low while FIFO holds 4 entries -> evt_valid=0 and all outputs 0 immediately, without waiting for a clock edge.
